// File: rtl/score_sseg_display.sv
`default_nettype none
// ============================================================================
//  Module   : score_sseg_display
//  Brief    : Score-to-BCD double-dabble converter driving a 4-digit
//             multiplexed seven-segment display with leading-zero blanking.
//             Define SSEG_HEX_MODE_EN to show the raw score as hexadecimal.
//  Revision : 1.0  initial release
// ============================================================================
module score_sseg_display #(
   parameter int SCORE_W = 10,
   parameter int CLK_HZ  = 50000000,
   parameter int SCAN_HZ = 1000
) (
   input  logic               sys_clk,
   input  logic               sys_reset_n,
   input  logic [SCORE_W-1:0] iScore,
   output logic [7:0]         sseg_a_to_dp,
   output logic [3:0]         sseg_an,
   output logic [15:0]        oBcd,
   output logic               oBusy
);

   localparam int               DIV    = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
   localparam int               PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(DIV - 1);

`ifdef SSEG_HEX_MODE_EN

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         oBcd <= 16'h0000;
      end else begin
         oBcd <= 16'(iScore);
      end
   end

   assign oBusy = 1'b0;

`else

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   localparam int CNT_W = $clog2(SCORE_W + 1);

   conv_state_t        state;
   conv_state_t        state_nxt;
   logic [SCORE_W-1:0] last_score;
   logic [SCORE_W-1:0] shreg;
   logic [SCORE_W-1:0] score_sat;
   logic [15:0]        acc;
   logic [15:0]        acc_adj;
   logic [CNT_W-1:0]   iter;
   logic               busy;
   logic               start;
   logic               last_iter;

   // Only widths that can exceed four decimal digits need clamping.
   generate
      if (SCORE_W >= 14) begin : g_sat
         assign score_sat = (iScore > SCORE_W'(9999)) ? SCORE_W'(9999) : iScore;
      end else begin : g_nosat
         assign score_sat = iScore;
      end
   endgenerate

   assign start     = (state == IDLE) && (iScore != last_score);
   assign last_iter = (iter == CNT_W'(SCORE_W - 1));
   assign oBusy     = busy;

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_iter) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      acc_adj = acc;
      for (int k = 0; k < 4; k++) begin
         if (acc[4*k +: 4] >= 4'd5) begin
            acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         last_score <= '0;
         shreg      <= '0;
         acc        <= 16'h0000;
         iter       <= '0;
         busy       <= 1'b0;
         oBcd       <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg      <= score_sat;
                  acc        <= 16'h0000;
                  last_score <= iScore;
                  iter       <= '0;
                  busy       <= 1'b1;
               end
            end
            SHIFT: begin
               acc   <= (acc_adj << 1) | 16'(shreg[SCORE_W-1]);
               shreg <= shreg << 1;
               iter  <= iter + 1'b1;
            end
            COMMIT: begin
               oBcd <= acc;
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

`endif

   logic [PRE_W-1:0] pre;
   logic             tick;
   logic [1:0]       scan_idx;
   logic [3:0]       digit;
   logic             blank;
   logic [7:0]       seg_code;

   assign tick = (pre == PRE_TC);

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         pre      <= '0;
         scan_idx <= 2'd0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) begin
            scan_idx <= scan_idx + 2'd1;
         end
      end
   end

   // A digit goes dark only when it and every digit above it are zero.
   always_comb begin
      digit = oBcd[{scan_idx, 2'b00} +: 4];
      case (scan_idx)
         2'd3:    blank = (oBcd[15:12] == 4'h0);
         2'd2:    blank = (oBcd[15:8] == 8'h00);
         2'd1:    blank = (oBcd[15:4] == 12'h000);
         default: blank = 1'b0;
      endcase
   end

   always_comb begin
      seg_code = 8'hFF;
      case (digit)
         4'h0: seg_code = 8'hC0;
         4'h1: seg_code = 8'hF9;
         4'h2: seg_code = 8'hA4;
         4'h3: seg_code = 8'hB0;
         4'h4: seg_code = 8'h99;
         4'h5: seg_code = 8'h92;
         4'h6: seg_code = 8'h82;
         4'h7: seg_code = 8'hF8;
         4'h8: seg_code = 8'h80;
         4'h9: seg_code = 8'h90;
         4'hA: seg_code = 8'h88;
         4'hB: seg_code = 8'h83;
         4'hC: seg_code = 8'hC6;
         4'hD: seg_code = 8'hA1;
         4'hE: seg_code = 8'h86;
         4'hF: seg_code = 8'h8E;
         default: seg_code = 8'hFF;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         sseg_an      <= 4'b1111;
         sseg_a_to_dp <= 8'hFF;
      end else begin
         sseg_an      <= ~(4'b0001 << scan_idx);
         sseg_a_to_dp <= blank ? 8'hFF : seg_code;
      end
   end

endmodule
`default_nettype wire
